// File: rtl/fifo_frame_lcl.sv
// Frame-buffering FIFO with a queue of complete frame lengths and watermark pacing.
// Define FIFO_FRAME_LCL_FWFT_EN for first-word-fall-through reads; default is registered read.
module fifo_frame_lcl #(
    parameter int DW     = 64,
    parameter int AW     = 8,
    parameter int FQ_AW  = 2,
    parameter int IH_LIM = (1 << AW) - 6,
    parameter int IL_LIM = (1 << AW) / 2,
    parameter int OH_LIM = (1 << AW) / 2,
    parameter int OL_LIM = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             den,
    input  logic [DW-1:0]    din,
    input  logic             iend,
    output logic             irdy,
    input  logic             rdrq,
    output logic [DW-1:0]    dout,
    output logic             dv,
    output logic             olast,
    output logic             ordy,
    output logic             empty,
    output logic             flush,
    output logic [FQ_AW:0]   frames,
    output logic [AW:0]      cnt,
    output logic             ovfl,
    output logic             udfl
);

    localparam int DEPTH    = 1 << AW;
    localparam int FQ_DEPTH = 1 << FQ_AW;
    localparam logic [AW:0]    DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0]    IH_C      = (AW+1)'(IH_LIM);
    localparam logic [AW:0]    IL_C      = (AW+1)'(IL_LIM);
    localparam logic [AW:0]    OH_C      = (AW+1)'(OH_LIM);
    localparam logic [AW:0]    OL_C      = (AW+1)'(OL_LIM);
    localparam logic [AW:0]    ONE_C     = (AW+1)'(1);
    localparam logic [FQ_AW:0] FQ_FULL_C = (FQ_AW+1)'(FQ_DEPTH);
    localparam logic [FQ_AW:0] FQ_ONE_C  = (FQ_AW+1)'(1);

    logic [DW-1:0]  mem_q [DEPTH];
    logic [AW:0]    fq_mem_q [FQ_DEPTH];

    logic [AW:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]    i_cnt_q, i_cnt_d, o_cnt_q, o_cnt_d;
    logic [FQ_AW:0] fq_wp_q, fq_wp_d, fq_rp_q, fq_rp_d;
    logic           ovfl_q, ovfl_d, udfl_q, udfl_d;
    logic           irdy_q, irdy_d, ordy_q, ordy_d;

    logic [AW:0]    cnt_s, cnt_next_s, len_s, head_len_s;
    logic [FQ_AW:0] frames_s, frames_next_s;
    logic           full_s, empty_s, fq_full_s;
    logic           wr_en_s, rd_en_s, push_s, olast_s;

    // Datapath decode, pointer/counter next state and watermark pacing.
    always_comb begin
        cnt_s      = wr_ptr_q - rd_ptr_q;
        full_s     = (cnt_s == DEPTH_C);
        empty_s    = (cnt_s == '0);
        frames_s   = fq_wp_q - fq_rp_q;
        fq_full_s  = (frames_s == FQ_FULL_C);
        head_len_s = fq_mem_q[fq_rp_q[FQ_AW-1:0]];
        wr_en_s    = den & ~full_s;
        rd_en_s    = rdrq & ~empty_s;
        len_s      = i_cnt_q + {{AW{1'b0}}, wr_en_s};
        // Streamed words count toward o_cnt even before their length is known.
        olast_s    = rd_en_s & (frames_s != '0) & (o_cnt_q == head_len_s - ONE_C);
        push_s     = iend & (len_s != '0) & ~fq_full_s;

        wr_ptr_d = wr_en_s ? wr_ptr_q + ONE_C : wr_ptr_q;
        rd_ptr_d = rd_en_s ? rd_ptr_q + ONE_C : rd_ptr_q;
        fq_wp_d  = push_s  ? fq_wp_q + FQ_ONE_C : fq_wp_q;
        fq_rp_d  = olast_s ? fq_rp_q + FQ_ONE_C : fq_rp_q;

        if (iend) begin
            i_cnt_d = '0;
        end else if (wr_en_s) begin
            i_cnt_d = i_cnt_q + ONE_C;
        end else begin
            i_cnt_d = i_cnt_q;
        end

        if (olast_s) begin
            o_cnt_d = '0;
        end else if (rd_en_s) begin
            o_cnt_d = o_cnt_q + ONE_C;
        end else begin
            o_cnt_d = o_cnt_q;
        end

        ovfl_d = ovfl_q | (den & full_s) | (iend & (len_s != '0) & fq_full_s);
        udfl_d = udfl_q | (rdrq & empty_s);

        cnt_next_s    = wr_ptr_d - rd_ptr_d;
        frames_next_s = fq_wp_d - fq_rp_d;

        if (frames_next_s == FQ_FULL_C) begin
            irdy_d = 1'b0;
        end else if (cnt_next_s <= IL_C) begin
            irdy_d = 1'b1;
        end else if (cnt_next_s >= IH_C) begin
            irdy_d = 1'b0;
        end else begin
            irdy_d = irdy_q;
        end

        if (frames_next_s != '0) begin
            ordy_d = 1'b1;
        end else if (cnt_next_s <= OL_C) begin
            ordy_d = 1'b0;
        end else if (cnt_next_s >= OH_C) begin
            ordy_d = 1'b1;
        end else begin
            ordy_d = ordy_q;
        end
    end

    // Storage arrays are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
        if (push_s) begin
            fq_mem_q[fq_wp_q[FQ_AW-1:0]] <= len_s;
        end
    end

    // Control state with synchronous reset and clear.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            i_cnt_q  <= '0;
            o_cnt_q  <= '0;
            fq_wp_q  <= '0;
            fq_rp_q  <= '0;
            ovfl_q   <= 1'b0;
            udfl_q   <= 1'b0;
            irdy_q   <= 1'b0;
            ordy_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            i_cnt_q  <= i_cnt_d;
            o_cnt_q  <= o_cnt_d;
            fq_wp_q  <= fq_wp_d;
            fq_rp_q  <= fq_rp_d;
            ovfl_q   <= ovfl_d;
            udfl_q   <= udfl_d;
            irdy_q   <= irdy_d;
            ordy_q   <= ordy_d;
        end
    end

`ifdef FIFO_FRAME_LCL_FWFT_EN
    assign dout = mem_q[rd_ptr_q[AW-1:0]];
    assign dv   = ~empty_s;
`else
    logic [DW-1:0] dout_q, dout_d;
    logic          dv_q, dv_d;

    // Registered read port: popped word appears one cycle after rdrq.
    always_comb begin
        dv_d   = rd_en_s;
        dout_d = dout_q;
        if (rd_en_s) begin
            dout_d = mem_q[rd_ptr_q[AW-1:0]];
        end else begin
            dout_d = dout_q;
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        if (rst | clr) begin
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    assign dout = dout_q;
    assign dv   = dv_q;
`endif

    assign irdy   = irdy_q;
    assign ordy   = ordy_q;
    assign ovfl   = ovfl_q;
    assign udfl   = udfl_q;
    assign olast  = olast_s;
    assign empty  = empty_s;
    assign flush  = (frames_s != '0);
    assign frames = frames_s;
    assign cnt    = cnt_s;

endmodule

// File: tb/tb_fifo_frame_lcl.sv
// Scoreboard bench for fifo_frame_lcl in default configuration (DEPTH 256, 4-frame queue).
module tb_fifo_frame_lcl;

    logic        clk = 1'b0;
    logic        rst, clr, den, iend, rdrq;
    logic [63:0] din;
    logic        irdy, dout_v, olast, ordy, empty, flush, ovfl, udfl;
    logic [63:0] dout;
    logic [2:0]  frames;
    logic [8:0]  cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] mq[$];
    logic [63:0] exp_data[$];
    logic        exp_last[$];

    fifo_frame_lcl dut (
        .clk(clk), .rst(rst), .clr(clr), .den(den), .din(din), .iend(iend),
        .irdy(irdy), .rdrq(rdrq), .dout(dout), .dv(dout_v), .olast(olast),
        .ordy(ordy), .empty(empty), .flush(flush), .frames(frames), .cnt(cnt),
        .ovfl(ovfl), .udfl(udfl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; the model judges full/empty on pre-cycle occupancy.
    task automatic cycle(input logic d, input logic [63:0] x, input logic e,
                         input logic r, input logic l);
        bit acc_w, acc_r;
        acc_w = d && (mq.size() < 256);
        acc_r = r && (mq.size() > 0);
        if (r) exp_last.push_back(l);
        if (acc_r) exp_data.push_back(mq.pop_front());
        if (acc_w) mq.push_back(x);
        den = d; din = x; iend = e; rdrq = r;
        @(posedge clk); #1;
        den = 1'b0; din = 64'd0; iend = 1'b0; rdrq = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rdrq === 1'b1) begin
            if (exp_last.size() == 0) chk("olast_queue", 64'd1, 64'd0);
            else chk("olast", {63'd0, olast}, {63'd0, exp_last.pop_front()});
        end
        if (dout_v === 1'b1) begin
            if (exp_data.size() == 0) chk("unexpected_dv", 64'd1, 64'd0);
            else chk("dout", dout, exp_data.pop_front());
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; den = 1'b0; iend = 1'b0; rdrq = 1'b0; din = 64'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_irdy",   {63'd0, irdy},   64'd0);
        chk("rst_ordy",   {63'd0, ordy},   64'd0);
        chk("rst_dv",     {63'd0, dout_v}, 64'd0);
        chk("rst_empty",  {63'd0, empty},  64'd1);
        chk("rst_flush",  {63'd0, flush},  64'd0);
        chk("rst_frames", {61'd0, frames}, 64'd0);
        chk("rst_cnt",    {55'd0, cnt},    64'd0);
        chk("rst_ovfl",   {63'd0, ovfl},   64'd0);
        chk("rst_udfl",   {63'd0, udfl},   64'd0);
        chk("rst_dout",   dout,            64'd0);
        chk("rst_olast",  {63'd0, olast},  64'd0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("irdy_after_rst", {63'd0, irdy}, 64'd1);

        // Single 10-word frame.
        for (int i = 0; i < 10; i++) cycle(1'b1, 64'(i), i == 9, 1'b0, 1'b0);
        chk("f10_frames", {61'd0, frames}, 64'd1);
        chk("f10_cnt",    {55'd0, cnt},    64'd10);
        chk("f10_flush",  {63'd0, flush},  64'd1);
        chk("f10_ordy",   {63'd0, ordy},   64'd1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1, i == 9);
        chk("f10_frames_after", {61'd0, frames}, 64'd0);
        chk("f10_ordy_fall",    {63'd0, ordy},   64'd0);
        chk("f10_empty",        {63'd0, empty},  64'd1);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        // Frames of 3, 5 and 2 words back to back.
        for (int i = 0; i < 10; i++)
            cycle(1'b1, 64'(100 + i), (i == 2) || (i == 7) || (i == 9), 1'b0, 1'b0);
        chk("f352_frames", {61'd0, frames}, 64'd3);
        chk("f352_cnt",    {55'd0, cnt},    64'd10);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 64'd0, 1'b0, 1'b1, (i == 2) || (i == 7) || (i == 9));
        chk("f352_frames_after", {61'd0, frames}, 64'd0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        // Stream 150 words before the frame end is known.
        for (int i = 0; i < 150; i++) begin
            cycle(1'b1, 64'(200 + i), 1'b0, 1'b0, 1'b0);
            if (i == 126) chk("stream_ordy_127", {63'd0, ordy}, 64'd0);
            if (i == 127) chk("stream_ordy_128", {63'd0, ordy}, 64'd1);
        end
        for (int i = 0; i < 140; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("stream_cnt_10", {55'd0, cnt}, 64'd10);
        cycle(1'b0, 64'd0, 1'b1, 1'b0, 1'b0);
        chk("stream_frames", {61'd0, frames}, 64'd1);
        for (int i = 0; i < 10; i++) cycle(1'b0, 64'd0, 1'b0, 1'b1, i == 9);
        chk("stream_frames_after", {61'd0, frames}, 64'd0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);

        // Read on an empty FIFO.
        cycle(1'b0, 64'd0, 1'b0, 1'b1, 1'b0);
        chk("udfl_set",   {63'd0, udfl},   64'd1);
        chk("udfl_cnt",   {55'd0, cnt},    64'd0);
        chk("udfl_dv",    {63'd0, dout_v}, 64'd0);
        chk("udfl_empty", {63'd0, empty},  64'd1);

        // Fill to capacity, then one word too many.
        for (int i = 0; i < 256; i++) begin
            cycle(1'b1, 64'(400 + i), 1'b0, 1'b0, 1'b0);
            if (i == 248) chk("fill_irdy_249", {63'd0, irdy}, 64'd1);
        end
        chk("fill_cnt",  {55'd0, cnt},  64'd256);
        chk("fill_irdy", {63'd0, irdy}, 64'd0);
        chk("fill_ovfl", {63'd0, ovfl}, 64'd0);
        cycle(1'b1, 64'd999, 1'b0, 1'b0, 1'b0);
        chk("ovfl_set", {63'd0, ovfl}, 64'd1);
        chk("ovfl_cnt", {55'd0, cnt},  64'd256);

        // Clear returns everything to its reset state.
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        mq.delete();
        chk("clr_ovfl", {63'd0, ovfl}, 64'd0);
        chk("clr_udfl", {63'd0, udfl}, 64'd0);
        chk("clr_cnt",  {55'd0, cnt},  64'd0);
        chk("clr_irdy", {63'd0, irdy}, 64'd0);
        cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("clr_irdy_next", {63'd0, irdy}, 64'd1);

        // Length queue full: four 2-word frames, then a fifth.
        for (int f = 0; f < 4; f++)
            for (int k = 0; k < 2; k++)
                cycle(1'b1, 64'(500 + 2 * f + k), k == 1, 1'b0, 1'b0);
        chk("fq_frames4", {61'd0, frames}, 64'd4);
        chk("fq_irdy",    {63'd0, irdy},   64'd0);
        cycle(1'b1, 64'd508, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 64'd509, 1'b1, 1'b0, 1'b0);
        chk("fq_ovfl",      {63'd0, ovfl},   64'd1);
        chk("fq_frames",    {61'd0, frames}, 64'd4);
        chk("fq_cnt",       {55'd0, cnt},    64'd10);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 64'd0, 1'b0, 1'b1, (i == 1) || (i == 3) || (i == 5) || (i == 7));
            if (i == 0) chk("fq_irdy_before_olast", {63'd0, irdy}, 64'd1 - 64'd1);
            if (i == 1) chk("fq_irdy_after_olast",  {63'd0, irdy}, 64'd1);
        end
        chk("fq_frames_end", {61'd0, frames}, 64'd0);
        repeat (2) cycle(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        chk("sb_data_drained", 64'(exp_data.size()), 64'd0);
        chk("sb_last_drained", 64'(exp_last.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_frame_lcl.md
# fifo_frame_lcl

Parametrised frame-buffering FIFO for the local AXI data path: the next generation of the fixed 256x64 single-frame buffer. It adds configurable width and depth, self-contained storage, and a queue of up to 2^FQ_AW complete frame lengths. Input of frame N+1 continues while frame N drains. It sits between a frame producer (den/din/iend) and an AXI-side consumer (rdrq/dout/olast). Watermark-driven irdy/ordy pace both sides.

## Interface
- DW, 64, data width in bits
- AW, 8, address width; DEPTH = 2^AW words
- FQ_AW, 2, frame-length queue address width; up to 2^FQ_AW complete frames queued
- IH_LIM, DEPTH-6, irdy high-water mark (words)
- IL_LIM, DEPTH/2, irdy low-water mark
- OH_LIM, DEPTH/2, ordy high-water mark
- OL_LIM, 4, ordy low-water mark
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  synchronous clear, same effect as rst
- den  in  1  write strobe
- din  in  DW  write data
- iend  in  1  frame end; synced with or after the frame's last den
- irdy  out  1  producer may write; registered
- rdrq  in  1  read request
- dout  out  DW  read data
- dv  out  1  dout valid
- olast  out  1  combinational; this rdrq pops the last word of the head frame
- ordy  out  1  consumer may read; registered
- empty  out  1  no words stored
- flush  out  1  at least one complete frame queued
- frames  out  FQ_AW+1  complete frames queued
- cnt  out  AW+1  words stored
- ovfl  out  1  sticky overflow
- udfl  out  1  sticky underflow

## Operation
- Storage: DEPTH x DW RAM; wr_ptr/rd_ptr AW+1 bits, wrap naturally; cnt = wr_ptr - rd_ptr; full = (cnt == DEPTH); empty = (cnt == 0).
- Write: den & ~full stores din and increments i_cnt (AW+1 bits, words since last frame boundary). den & full: word dropped, i_cnt unchanged, ovfl <= 1.
- iend: length = i_cnt + accepted den in the same cycle. Pushed to length queue if length > 0; i_cnt <= 0. Zero-length iend is ignored. iend with queue full: ovfl <= 1, length discarded, i_cnt <= 0.
- Read: rdrq & ~empty pops one word and increments o_cnt (words since last olast). rdrq & empty: no pop, udfl <= 1.
- olast = rdrq & ~empty & (frames != 0) & (o_cnt == head_len - 1). On olast: o_cnt <= 0, length queue pops.
- Reading before iend (watermark streaming) is legal; o_cnt keeps counting and olast fires once the length arrives.
- flush = (frames != 0).
- irdy next: 0 if length queue full; else 1 if cnt <= IL_LIM; else 0 if cnt >= IH_LIM; else hold. Input is NOT blocked during flush.
- ordy next: 1 if frames_next != 0. Otherwise 0 if cnt <= OL_LIM, 1 if cnt >= OH_LIM, else hold.
- Simultaneous iend push and olast pop: frames unchanged. Simultaneous den and rdrq: both act, judged on pre-cycle full/empty.
- rst/clr: pointers, i_cnt, o_cnt, length queue, ovfl, udfl, irdy, ordy, dv all 0. RAM contents not cleared. Mid-frame reset discards all data.

## Timing
- Reset values: irdy 0, ordy 0, dv 0, ovfl 0, udfl 0, empty 1, flush 0, frames 0, cnt 0, olast 0, dout 0.
- irdy rises one cycle after reset release (cnt 0 <= IL_LIM).
- Base mode: dout/dv registered; dv = 1 exactly one cycle after an accepted rdrq, with the popped word on dout.
- olast is asserted in the same cycle as the rdrq it qualifies, not with dv.
- cnt/empty/frames update the cycle after the causing event.
- Producer must stop den within 5 cycles of irdy falling; consumer stops rdrq on olast when frames becomes 0.

## Configuration
- FIFO_FRAME_LCL_FWFT_EN defined: first-word-fall-through.
  - dout = RAM[rd_ptr] combinationally; dv = ~empty.
  - rdrq acknowledges the current dout; no read latency.
- Undefined: standard mode, one-cycle registered read latency as above.

## Test plan
- Write 10 words, iend with 10th den; read 10 -> olast on 10th rdrq only; frames 1->0; ordy falls next cycle; dout matches 0..9 in order.
- Frames of 3, 5, 2 words back to back, no reads -> frames=3, cnt=10. Read 10 -> olast on reads 3, 8 and 10.
- AW=4 (DEPTH 16): write 16 words, 17th den -> word dropped, ovfl=1, cnt=16. irdy fell once cnt >= 10.
- Stream 150 words without iend -> ordy rises when cnt >= 128. Drain 140, then iend -> olast on the 150th total read.
- rdrq on empty FIFO -> udfl=1, dv=0, no pointer change; clr -> udfl=0, ovfl=0, irdy back to 1 next cycle.
- Queue full (4 frames, FQ_AW=2), 5th iend -> ovfl=1, frames stays 4, irdy=0 until first olast.
